// File: rtl/context_switch_controller_pkg.sv
// rtl/context_switch_controller_pkg.sv - shared types and window-next helper for the context switch controller
package context_switch_controller_pkg;

  localparam int CTX_MAX_W = 16;

  typedef enum logic [1:0] {
    WIN_LOWER = 2'd0,
    WIN_UPPER = 2'd1,
    WIN_FULL  = 2'd2
  } win_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Round-robin successor inside [min,max]; anything outside the window snaps to min.
  function automatic logic [CTX_MAX_W-1:0] ctx_window_next(
    input logic [CTX_MAX_W-1:0] current,
    input logic [CTX_MAX_W-1:0] min,
    input logic [CTX_MAX_W-1:0] max
  );
    if ((current < min) || (current > max)) begin
      return min;
    end else if (current < max) begin
      return current + CTX_MAX_W'(1);
    end else begin
      return min;
    end
  endfunction

endpackage

// File: rtl/context_window_sel.sv
// rtl/context_window_sel.sv - window mode to [min,max] decode and next-context selection
module context_window_sel
  import context_switch_controller_pkg::*;
#(
  parameter int NUM_CONTEXTS = 2,
  parameter int CTX_W        = 1
) (
  input  logic [1:0]       i_window_mode,
  input  logic [CTX_W-1:0] i_current,
  output logic [CTX_W-1:0] o_next
);

  localparam int HALF = NUM_CONTEXTS / 2;

  logic [CTX_W-1:0] w_min;
  logic [CTX_W-1:0] w_max;

  // Modes 2 and 3 both select the full range; a single-context build is always full.
  always_comb begin
    w_min = '0;
    w_max = CTX_W'(NUM_CONTEXTS - 1);
    if (NUM_CONTEXTS > 1) begin
      case (i_window_mode)
        WIN_LOWER: w_max = CTX_W'(HALF - 1);
        WIN_UPPER: w_min = CTX_W'(HALF);
        default:   ;
      endcase
    end
  end

  always_comb begin
    o_next = CTX_W'(ctx_window_next(CTX_MAX_W'(i_current), CTX_MAX_W'(w_min), CTX_MAX_W'(w_max)));
  end

endmodule

// File: rtl/context_switch_controller.sv
// rtl/context_switch_controller.sv - sequences write/load context switches with a req/done handshake
module context_switch_controller
  import context_switch_controller_pkg::*;
#(
  parameter int NUM_CONTEXTS = 2,
  parameter int CTX_W        = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1,
  parameter int LOAD_LATENCY = 1,
  parameter int COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               switch_req,
  input  logic               skip_store,
  input  logic [1:0]         window_mode,
  input  logic               window_mode_valid,
  output logic               write_strobe,
  output logic               do_not_store,
  output logic [CTX_W-1:0]   current_context,
  output logic [CTX_W-1:0]   next_context,
  output logic               busy,
  output logic               switch_done,
  output logic [COUNT_W-1:0] switch_count
);

  localparam int LAT_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LOAD_LATENCY - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [1:0]         r_window;
  logic [1:0]         r_pend_mode;
  logic               r_pend_valid;
  logic               r_skip;
  logic [CTX_W-1:0]   r_current;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [COUNT_W-1:0] r_count;
  logic               r_write_strobe;
  logic               r_busy;
  logic               r_done;
  logic [1:0]         w_window;
  logic [CTX_W-1:0]   w_next;

  assign w_window = (NUM_CONTEXTS == 1) ? WIN_FULL : r_window;

  context_window_sel #(
    .NUM_CONTEXTS (NUM_CONTEXTS),
    .CTX_W        (CTX_W)
  ) u_window_sel (
    .i_window_mode (w_window),
    .i_current     (r_current),
    .o_next        (w_next)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (switch_req) w_state_next = WRITE;
      WRITE:   w_state_next = LOAD;
      LOAD:    if (r_lat_cnt == LAT_LAST) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_window       <= WIN_LOWER;
      r_pend_mode    <= WIN_LOWER;
      r_pend_valid   <= 1'b0;
      r_skip         <= 1'b0;
      r_current      <= '0;
      r_lat_cnt      <= '0;
      r_count        <= '0;
      r_write_strobe <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_write_strobe <= (w_state_next == WRITE);
      r_busy         <= (w_state_next != IDLE);
      r_done         <= (w_state_next == DONE);
      case (r_state)
        IDLE: begin
          if (window_mode_valid) r_window <= window_mode;
          if (switch_req) r_skip <= skip_store;
        end
        WRITE: begin
          r_current <= w_next;
          r_lat_cnt <= '0;
        end
        LOAD: begin
          r_lat_cnt <= r_lat_cnt + LAT_W'(1);
        end
        DONE: begin
          r_count <= r_count + COUNT_W'(1);
          // A window request arriving in DONE itself is newer than anything pending.
          if (window_mode_valid) begin
            r_window <= window_mode;
          end else if (r_pend_valid) begin
            r_window <= r_pend_mode;
          end
          r_pend_valid <= 1'b0;
        end
        default: ;
      endcase
      if (window_mode_valid && (r_state == WRITE || r_state == LOAD)) begin
        r_pend_valid <= 1'b1;
        r_pend_mode  <= window_mode;
      end
    end
  end

  assign write_strobe    = r_write_strobe;
  assign do_not_store    = r_write_strobe & (r_skip | (w_next == r_current));
  assign current_context = r_current;
  assign next_context    = w_next;
  assign busy            = r_busy;
  assign switch_done     = r_done;
  assign switch_count    = r_count;

endmodule

// File: tb/tb_context_switch_controller.sv
// tb/tb_context_switch_controller.sv - scoreboard bench for context_switch_controller (N=4/L=1 and N=2/L=2)
module tb_context_switch_controller;

  typedef struct {
    int dut;
    int cur;
    int nxt;
    int dns;
  } ws_exp_t;

  typedef struct {
    int dut;
    int cur;
    int cnt;
  } done_exp_t;

  logic        clk;
  logic        reset;

  logic        a_req, a_skip, a_wmv;
  logic [1:0]  a_mode;
  logic        a_ws, a_dns, a_busy, a_done;
  logic [1:0]  a_cur, a_next;
  logic [15:0] a_count;

  logic        b_req, b_skip, b_wmv;
  logic [1:0]  b_mode;
  logic        b_ws, b_dns, b_busy, b_done;
  logic [0:0]  b_cur, b_next;
  logic [15:0] b_count;

  ws_exp_t   ws_q[$];
  done_exp_t done_q[$];
  int total = 0;
  int bad   = 0;

  context_switch_controller #(.NUM_CONTEXTS(4), .LOAD_LATENCY(1), .COUNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .switch_req(a_req), .skip_store(a_skip),
    .window_mode(a_mode), .window_mode_valid(a_wmv), .write_strobe(a_ws),
    .do_not_store(a_dns), .current_context(a_cur), .next_context(a_next),
    .busy(a_busy), .switch_done(a_done), .switch_count(a_count)
  );

  context_switch_controller #(.NUM_CONTEXTS(2), .LOAD_LATENCY(2), .COUNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .switch_req(b_req), .skip_store(b_skip),
    .window_mode(b_mode), .window_mode_valid(b_wmv), .write_strobe(b_ws),
    .do_not_store(b_dns), .current_context(b_cur), .next_context(b_next),
    .busy(b_busy), .switch_done(b_done), .switch_count(b_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_ws(input int dut, input int cur, input int nxt, input int dns);
    ws_exp_t e;
    if (ws_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL ws_unexpected dut=%0d cur=%0d nxt=%0d at %0t", dut, cur, nxt, $time);
    end else begin
      e = ws_q.pop_front();
      chk("ws_dut", dut, e.dut);
      chk("ws_cur", cur, e.cur);
      chk("ws_next", nxt, e.nxt);
      chk("ws_dns", dns, e.dns);
    end
  endtask

  task automatic mon_done(input int dut, input int cur, input int cnt);
    done_exp_t e;
    if (done_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL done_unexpected dut=%0d cur=%0d at %0t", dut, cur, $time);
    end else begin
      e = done_q.pop_front();
      chk("done_dut", dut, e.dut);
      chk("done_cur", cur, e.cur);
      chk("done_cnt", cnt, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (a_ws) mon_ws(0, int'(a_cur), int'(a_next), int'(a_dns));
    if (b_ws) mon_ws(1, int'(b_cur), int'(b_next), int'(b_dns));
    if (a_done) mon_done(0, int'(a_cur), int'(a_count));
    if (b_done) mon_done(1, int'(b_cur), int'(b_count));
  end

  // Entered and left at #1 after a rising edge; one switch on dut_a with a 6-cycle spacing.
  task automatic sw_a(input int wmv, input int mode, input int skip,
                      input int e_cur, input int e_nxt, input int e_dns, input int e_cnt);
    ws_q.push_back('{0, e_cur, e_nxt, e_dns});
    done_q.push_back('{0, e_nxt, e_cnt});
    a_req  = 1'b1;
    a_skip = 1'(skip);
    a_wmv  = 1'(wmv);
    a_mode = 2'(mode);
    @(posedge clk); #1;
    a_req  = 1'b0;
    a_skip = 1'b0;
    a_wmv  = 1'b0;
    chk("a_ws_t1", int'(a_ws), 1);
    chk("a_busy_t1", int'(a_busy), 1);
    @(posedge clk); #1;
    chk("a_ws_load", int'(a_ws), 0);
    chk("a_done_load", int'(a_done), 0);
    @(posedge clk); #1;
    chk("a_done_t3", int'(a_done), 1);
    @(posedge clk); #1;
    chk("a_busy_idle", int'(a_busy), 0);
    chk("a_cnt_after", int'(a_count), e_cnt + 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic sw_b(input int e_cur, input int e_nxt, input int e_dns, input int e_cnt);
    ws_q.push_back('{1, e_cur, e_nxt, e_dns});
    done_q.push_back('{1, e_nxt, e_cnt});
    b_req = 1'b1;
    @(posedge clk); #1;
    b_req = 1'b0;
    chk("b_ws_t1", int'(b_ws), 1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    a_req  = 1'b0; a_skip = 1'b0; a_wmv = 1'b0; a_mode = 2'd0;
    b_req  = 1'b0; b_skip = 1'b0; b_wmv = 1'b0; b_mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_a_cur", int'(a_cur), 0);
    chk("rst_a_next", int'(a_next), 1);
    chk("rst_a_ws", int'(a_ws), 0);
    chk("rst_a_dns", int'(a_dns), 0);
    chk("rst_a_busy", int'(a_busy), 0);
    chk("rst_a_done", int'(a_done), 0);
    chk("rst_a_cnt", int'(a_count), 0);
    chk("rst_b_cur", int'(b_cur), 0);
    chk("rst_b_next", int'(b_next), 0);
    chk("rst_b_cnt", int'(b_count), 0);

    // LOWER window on four contexts ping-pongs between 0 and 1
    sw_a(0, 0, 0, 0, 1, 0, 0);
    sw_a(0, 0, 0, 1, 0, 0, 1);
    sw_a(0, 0, 0, 0, 1, 0, 2);
    chk("a_cnt_3", int'(a_count), 3);
    chk("a_cur_1", int'(a_cur), 1);

    // UPPER loaded on the same edge as the request
    sw_a(1, 1, 0, 1, 2, 0, 3);
    sw_a(0, 0, 0, 2, 3, 0, 4);
    sw_a(0, 0, 0, 3, 2, 0, 5);
    chk("a_cnt_6", int'(a_count), 6);

    // FULL window, skip_store on the second switch only
    sw_a(1, 2, 0, 2, 3, 0, 6);
    sw_a(0, 0, 1, 3, 0, 1, 7);
    sw_a(0, 0, 0, 0, 1, 0, 8);
    sw_a(0, 0, 0, 1, 2, 0, 9);
    chk("a_cnt_10", int'(a_count), 10);
    chk("a_cur_2", int'(a_cur), 2);

    // Two contexts, LOWER: the only candidate is the resident context
    sw_b(0, 0, 1, 0);
    sw_b(0, 0, 1, 1);
    chk("b_cnt_2", int'(b_count), 2);
    chk("b_cur_0", int'(b_cur), 0);

    // Held request, L=2: switches at 5-cycle spacing; UPPER posted during the first LOAD
    ws_q.push_back('{1, 0, 0, 1});
    done_q.push_back('{1, 0, 2});
    ws_q.push_back('{1, 0, 1, 0});
    done_q.push_back('{1, 1, 3});
    ws_q.push_back('{1, 1, 1, 1});
    done_q.push_back('{1, 1, 4});
    b_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_wmv  = 1'b1;
    b_mode = 2'd1;
    @(posedge clk); #1;
    b_wmv  = 1'b0;
    chk("b_next_win_held", int'(b_next), 0);
    chk("b_busy_held", int'(b_busy), 1);
    repeat (8) @(posedge clk);
    #1;
    b_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("b_cnt_5", int'(b_count), 5);
    chk("b_busy_end", int'(b_busy), 0);
    chk("b_cur_end", int'(b_cur), 1);

    // Reset during LOAD: no DONE, state and counters back to reset values
    ws_q.push_back('{0, 2, 3, 0});
    a_req = 1'b1;
    @(posedge clk); #1;
    a_req = 1'b0;
    chk("a_ws_pre_rst", int'(a_ws), 1);
    @(posedge clk); #1;
    chk("a_busy_load", int'(a_busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_busy", int'(a_busy), 0);
    chk("rst2_cur", int'(a_cur), 0);
    chk("rst2_done", int'(a_done), 0);
    chk("rst2_cnt", int'(a_count), 0);
    chk("rst2_next", int'(a_next), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("rst2_cnt_later", int'(a_count), 0);

    chk("ws_q_empty", ws_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
